// File: rtl/uart_rx8.sv
// 8N1 serial byte receiver: two-flop synchronizer, centre-of-bit sampling,
// one-cycle wr_en strobe per good byte and a sticky framing-error flag.
module uart_rx8 #(
    parameter  int CLKS_PER_BIT = 434,
    localparam int HALF_BIT     = CLKS_PER_BIT / 2,
    localparam int CW           = $clog2(CLKS_PER_BIT)
) (
    input  logic       clock,
    input  logic       reset_N,
    input  logic       rxd,
    output logic [7:0] out,
    output logic       wr_en,
    output logic       busy,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        RECOVER = 3'd4
    } state_t;

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    state_t        state_q, state_d;
    logic          s1_q, s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    out_q, out_d;
    logic          wr_en_q, wr_en_d;
    logic          frame_err_q, frame_err_d;

    // Synchronizer flops reset high so a reset never looks like a start bit.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            out_q       <= '0;
            wr_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            s1_q        <= rxd;
            s2_q        <= s1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            out_q       <= out_d;
            wr_en_q     <= wr_en_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        out_d       = out_q;
        wr_en_d     = 1'b0;
        frame_err_d = frame_err_q;

        case (state_q)
            IDLE: begin
                if (!s2_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            // Re-check the line half a bit in so a short glitch is ignored.
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = s2_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {s2_q, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (s2_q) begin
                        out_d       = shreg_q;
                        wr_en_d     = 1'b1;
                        frame_err_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = RECOVER;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // A held-low break stays here, yielding a single framing error.
            RECOVER: begin
                if (s2_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out       = out_q;
    assign wr_en     = wr_en_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx8.sv
// Randomized self-checking bench for uart_rx8: a fast instance (8 clocks/bit)
// for the functional scenarios and a 434 clocks/bit instance for baud skew.
module tb_uart_rx8;

    logic       clock;
    logic       reset_N;
    logic       rxd8, rxd434;
    logic [7:0] out8, out434;
    logic       wr_en8, wr_en434;
    logic       busy8, busy434;
    logic       ferr8, ferr434;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: byte-level view of what the line carried
    logic [7:0] exp_q[$];
    logic [7:0] model_out  = 8'h00;
    logic       model_ferr = 1'b0;

    // Observations
    logic [7:0] rx_q[$];
    int         rx_cyc_q[$];
    int         cyc = 0;
    int         wr_busy_clash = 0;
    int         ferr_rises = 0;
    logic       ferr8_prev = 1'b0;
    int         cnt434 = 0;
    logic [7:0] last434 = 8'h00;

    uart_rx8 #(.CLKS_PER_BIT(8)) dut8 (
        .clock(clock), .reset_N(reset_N), .rxd(rxd8),
        .out(out8), .wr_en(wr_en8), .busy(busy8), .frame_err(ferr8)
    );

    uart_rx8 #(.CLKS_PER_BIT(434)) dut434 (
        .clock(clock), .reset_N(reset_N), .rxd(rxd434),
        .out(out434), .wr_en(wr_en434), .busy(busy434), .frame_err(ferr434)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (wr_en8) begin
            rx_q.push_back(out8);
            rx_cyc_q.push_back(cyc);
            if (busy8) wr_busy_clash++;
        end
        if (ferr8 && !ferr8_prev) ferr_rises++;
        ferr8_prev = ferr8;
        if (wr_en434) begin
            cnt434++;
            last434 = out434;
        end
    end

    // Drives one frame on rxd8; caller must be at a negedge. t0 = posedges so far.
    task automatic send8(input logic [7:0] b, input logic stop_bit, output int t0);
        rxd8 = 1'b0;
        t0   = cyc;
        repeat (8) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rxd8 = b[i];
            repeat (8) @(negedge clock);
        end
        rxd8 = stop_bit;
        repeat (8) @(negedge clock);
        if (stop_bit) begin
            exp_q.push_back(b);
            model_out  = b;
            model_ferr = 1'b0;
        end else begin
            model_ferr = 1'b1;
        end
    endtask

    task automatic compare_stream(input string name);
        vectors++;
        if (rx_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("[TB] FAIL %s count: got %0d strobes, expected %0d", name, rx_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                vectors++;
                if (rx_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("[TB] FAIL %s byte%0d: got %h expected %h", name, i, rx_q[i], exp_q[i]);
                end
            end
        end
        vectors++;
        if (out8 !== model_out) begin
            miscompares++;
            $display("[TB] FAIL %s out: got %h expected %h", name, out8, model_out);
        end
        vectors++;
        if (ferr8 !== model_ferr) begin
            miscompares++;
            $display("[TB] FAIL %s frame_err: got %b expected %b", name, ferr8, model_ferr);
        end
        rx_q.delete();
        rx_cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        int t0;
        logic [7:0] b;
        vectors++;
        if ({out8, wr_en8, busy8, ferr8} !== 11'h000) begin
            miscompares++;
            $display("[TB] FAIL reset_init: got out=%h wr=%b busy=%b ferr=%b expected 00/0/0/0", out8, wr_en8, busy8, ferr8);
        end
        reset_N = 1'b1;
        repeat (4) @(negedge clock);
        b = 8'($urandom_range(1, 255));
        send8(b, 1'b1, t0);
        repeat (4) @(negedge clock);
        compare_stream("reset_pre");
        // partial frame, then asynchronous reset in the middle of a clock phase
        rxd8 = 1'b0;
        repeat (20) @(negedge clock);
        rxd8 = ~rxd8;
        #2 reset_N = 1'b0;
        #1;
        model_out  = 8'h00;
        model_ferr = 1'b0;
        vectors++;
        if ({out8, wr_en8, busy8, ferr8} !== 11'h000) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: got out=%h wr=%b busy=%b ferr=%b expected 00/0/0/0", out8, wr_en8, busy8, ferr8);
        end
        rxd8 = 1'b1;
        @(negedge clock);
        reset_N = 1'b1;
        repeat (3) @(negedge clock);
        b = 8'($urandom);
        send8(b, 1'b1, t0);
        repeat (4) @(negedge clock);
        compare_stream("reset_post");
    endtask

    task automatic test_single();
        int t0;
        send8(8'hA5, 1'b1, t0);
        repeat (4) @(negedge clock);
        vectors++;
        if (rx_cyc_q.size() != 1) begin
            miscompares++;
            $display("[TB] FAIL latency: got %0d strobes, expected 1", rx_cyc_q.size());
        end else begin
            vectors++;
            // first posedge seeing the low line is edge 0; strobe follows 2+4+8*8+8 edges later
            if (rx_cyc_q[0] != t0 + 1 + (2 + 4 + 8 * 8 + 8)) begin
                miscompares++;
                $display("[TB] FAIL latency: got %0d clocks, expected %0d", rx_cyc_q[0] - t0 - 1, 2 + 4 + 8 * 8 + 8);
            end
        end
        vectors++;
        if (wr_busy_clash != 0) begin
            miscompares++;
            $display("[TB] FAIL busy_at_wr: got %0d overlaps, expected 0", wr_busy_clash);
        end
        compare_stream("single_A5");
    endtask

    task automatic test_glitch();
        logic seen_busy = 1'b0;
        rxd8 = 1'b0;
        repeat (2) @(negedge clock);
        rxd8 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            seen_busy |= busy8;
        end
        vectors++;
        if (seen_busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL glitch_busy: got %b expected 1", seen_busy);
        end
        vectors++;
        if (busy8 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL glitch_idle: got busy=%b expected 0", busy8);
        end
        compare_stream("glitch");
    endtask

    task automatic test_frame_err();
        int t0;
        int waited = 0;
        ferr_rises = 0;
        send8(8'h3C, 1'b0, t0);
        repeat (40) @(negedge clock);
        vectors++;
        if (busy8 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL break_busy: got %b expected 1", busy8);
        end
        vectors++;
        if (ferr_rises != 1) begin
            miscompares++;
            $display("[TB] FAIL break_errors: got %0d expected 1", ferr_rises);
        end
        compare_stream("bad_3C");
        rxd8 = 1'b1;
        while (busy8 && waited < 10) begin
            @(negedge clock);
            waited++;
        end
        vectors++;
        if (busy8 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL recover_timeout: got busy=%b expected 0 within 10 clocks", busy8);
        end
        repeat (2) @(negedge clock);
        send8(8'h81, 1'b1, t0);
        repeat (4) @(negedge clock);
        compare_stream("good_81");
    endtask

    task automatic test_back_to_back();
        int t0;
        send8(8'h00, 1'b1, t0);
        send8(8'hFF, 1'b1, t0);
        repeat (4) @(negedge clock);
        compare_stream("b2b");
    endtask

    task automatic test_random();
        int t0;
        logic [7:0] b;
        logic stop_bit;
        for (int n = 0; n < 8; n++) begin
            b        = 8'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            send8(b, stop_bit, t0);
            if (!stop_bit) begin
                rxd8 = 1'b1;
                repeat (4) @(negedge clock);
            end else begin
                repeat ($urandom_range(0, 3)) @(negedge clock);
            end
        end
        repeat (4) @(negedge clock);
        compare_stream("random");
    endtask

    task automatic send434(input logic [7:0] b, input int bit_ns);
        @(negedge clock);
        rxd434 = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rxd434 = b[i];
            #(bit_ns);
        end
        rxd434 = 1'b1;
        #(bit_ns);
        repeat (10) @(negedge clock);
    endtask

    task automatic test_baud_skew();
        int periods[2];
        periods[0] = 4340 * 102 / 100;
        periods[1] = 4340 * 98 / 100;
        for (int k = 0; k < 2; k++) begin
            cnt434 = 0;
            send434(8'h5A, periods[k]);
            vectors++;
            if (cnt434 != 1 || last434 !== 8'h5A) begin
                miscompares++;
                $display("[TB] FAIL skew%0d: got %0d strobes byte %h, expected 1 strobe byte 5a", k, cnt434, last434);
            end
            vectors++;
            if (ferr434 !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL skew%0d frame_err: got %b expected 0", k, ferr434);
            end
        end
    endtask

    initial begin
        reset_N = 1'b0;
        rxd8    = 1'b1;
        rxd434  = 1'b1;
        repeat (3) @(negedge clock);
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_random();
        test_baud_skew();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
